// File: rtl/partition_error_sweeper.sv
// Exhaustive sweep engine that drives every input vector into an exact and an
// approximate copy of one logic partition and accumulates error metrics
// (mismatch count, Hamming sum, maximum absolute error, first failing vector).
module partition_error_sweeper #(
  parameter int IN_W    = 8,
  parameter int OUT_W   = 6,
  parameter int DUT_LAT = 0,
  parameter int HAM_W   = IN_W + $clog2(OUT_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [OUT_W-1:0]  po_mask,
  output logic [IN_W-1:0]   pi,
  input  logic [OUT_W-1:0]  po_exact,
  input  logic [OUT_W-1:0]  po_approx,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [IN_W:0]     err_count,
  output logic [HAM_W-1:0]  ham_sum,
  output logic [OUT_W-1:0]  max_abs_err,
  output logic [IN_W-1:0]   first_fail_vec,
  output logic              first_fail_valid
);

  localparam int EC_W  = IN_W + 1;
  localparam int PC_W  = $clog2(OUT_W + 1);
  localparam int LAT_W = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;
  localparam logic [IN_W-1:0]  PI_MAX     = {IN_W{1'b1}};
  localparam logic [IN_W-1:0]  PI_ONE     = IN_W'(32'd1);
  localparam logic [EC_W-1:0]  EC_ONE     = EC_W'(32'd1);
  localparam logic [LAT_W-1:0] LAT_ONE    = LAT_W'(32'd1);
  localparam logic [LAT_W-1:0] DRAIN_LAST = LAT_W'((DUT_LAT > 0) ? (DUT_LAT - 1) : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Number of set bits in a masked difference word.
  function automatic logic [PC_W-1:0] popcount(input logic [OUT_W-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < OUT_W; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

  // Unsigned absolute difference of two output words.
  function automatic logic [OUT_W-1:0] abs_diff(input logic [OUT_W-1:0] a,
                                                input logic [OUT_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  state_t              state_r, state_nx_s;
  logic [OUT_W-1:0]    mask_r;
  logic [IN_W-1:0]     pi_r;
  logic [LAT_W-1:0]    drain_cnt_r;
  logic                busy_r, done_r, aborted_r, ffv_valid_r;
  logic [EC_W-1:0]     err_count_r;
  logic [HAM_W-1:0]    ham_sum_r;
  logic [OUT_W-1:0]    max_abs_r;
  logic [IN_W-1:0]     ffv_r;

  logic                start_acc_s, busy_state_s, abort_s;
  logic                cmp_valid_s, cmp_fire_s;
  logic [IN_W-1:0]     cmp_idx_s;
  logic [OUT_W-1:0]    diff_s, abs_s;
  logic [PC_W-1:0]     ham_inc_s;

  assign busy_state_s = (state_r == SWEEP) || (state_r == DRAIN);
  assign start_acc_s  = (state_r == IDLE) && start;
  assign abort_s      = busy_state_s && abort;

  // Tag pipeline: a compare retires DUT_LAT cycles after its vector is issued.
  generate
    if (DUT_LAT == 0) begin : g_no_lat
      assign cmp_valid_s = (state_r == SWEEP);
      assign cmp_idx_s   = pi_r;
    end else begin : g_lat
      logic [DUT_LAT-1:0] vld_r;
      logic [IN_W-1:0]    idx_r [DUT_LAT];

      // Shift {valid, index} tags; an abort flushes every in-flight valid.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_r <= '0;
          for (int i = 0; i < DUT_LAT; i++) idx_r[i] <= '0;
        end else if (abort_s) begin
          vld_r <= '0;
        end else begin
          vld_r[0] <= (state_r == SWEEP);
          idx_r[0] <= pi_r;
          for (int i = 1; i < DUT_LAT; i++) begin
            vld_r[i] <= vld_r[i-1];
            idx_r[i] <= idx_r[i-1];
          end
        end
      end

      assign cmp_valid_s = vld_r[DUT_LAT-1];
      assign cmp_idx_s   = idx_r[DUT_LAT-1];
    end
  endgenerate

  assign cmp_fire_s = cmp_valid_s && !abort_s;
  assign diff_s     = (po_exact ^ po_approx) & mask_r;
  assign ham_inc_s  = popcount(diff_s);
  assign abs_s      = abs_diff(po_exact & mask_r, po_approx & mask_r);

  // Next-state selection for the sweep sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nx_s = SWEEP;
        else       state_nx_s = IDLE;
      end
      SWEEP: begin
        if (abort)                state_nx_s = IDLE;
        else if (pi_r == PI_MAX)  state_nx_s = (DUT_LAT > 0) ? DRAIN : DONE;
        else                      state_nx_s = SWEEP;
      end
      DRAIN: begin
        if (abort)                          state_nx_s = IDLE;
        else if (drain_cnt_r == DRAIN_LAST) state_nx_s = DONE;
        else                                state_nx_s = DRAIN;
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State, stimulus counter, drain counter and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pi_r        <= '0;
      drain_cnt_r <= '0;
      mask_r      <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      aborted_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == SWEEP) || (state_nx_s == DRAIN);
      done_r  <= (state_nx_s == DONE);
      if (start_acc_s) begin
        pi_r      <= '0;
        mask_r    <= po_mask;
        aborted_r <= 1'b0;
      end else begin
        if ((state_r == SWEEP) && (pi_r != PI_MAX)) pi_r <= pi_r + PI_ONE;
        if (abort_s) aborted_r <= 1'b1;
      end
      if (state_r == DRAIN) drain_cnt_r <= drain_cnt_r + LAT_ONE;
      else                  drain_cnt_r <= '0;
    end
  end

  // Error metric accumulation on each retiring compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_r <= '0;
      ham_sum_r   <= '0;
      max_abs_r   <= '0;
      ffv_r       <= '0;
      ffv_valid_r <= 1'b0;
    end else if (start_acc_s) begin
      err_count_r <= '0;
      ham_sum_r   <= '0;
      max_abs_r   <= '0;
      ffv_r       <= '0;
      ffv_valid_r <= 1'b0;
    end else if (cmp_fire_s) begin
      ham_sum_r <= ham_sum_r + HAM_W'(ham_inc_s);
      if (abs_s > max_abs_r) max_abs_r <= abs_s;
      if (diff_s != '0) begin
        err_count_r <= err_count_r + EC_ONE;
        if (!ffv_valid_r) begin
          ffv_r       <= cmp_idx_s;
          ffv_valid_r <= 1'b1;
        end
      end
    end
  end

  assign pi               = pi_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign aborted          = aborted_r;
  assign err_count        = err_count_r;
  assign ham_sum          = ham_sum_r;
  assign max_abs_err      = max_abs_r;
  assign first_fail_vec   = ffv_r;
  assign first_fail_valid = ffv_valid_r;

endmodule
